// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
//   state_t         : FSM state encoding (also exported on the debug port)
//   OPC_W           : width of the opcode field at the top of an instruction
//   HALT_OPCODE_DEF : default opcode value that marks a halt instruction
package fetch_seq_pkg;

  localparam int OPC_W = 6;
  localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_out_stage.sv
// Single-entry valid/ready output register toward decode.
//   clk, rst  : clock, asynchronous active-low reset
//   load_i    : capture data_i/pc_i and mark valid
//   hold_i    : keep current contents (downstream not accepting a valid word)
//   flush_i   : drop the held word, overrides hold and load
//   data_i    : instruction word to capture
//   pc_i      : fetch address of that word
//   valid_o   : held word is valid
//   data_o    : held instruction word
//   pc_o      : fetch address of the held word
module fetch_out_stage #(
  parameter int AWIDTH = 6,
  parameter int RWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [RWIDTH-1:0] data_i,
  input  logic [AWIDTH-1:0] pc_i,
  output logic              valid_o,
  output logic [RWIDTH-1:0] data_o,
  output logic [AWIDTH-1:0] pc_o
);

  logic              valid_q;
  logic [RWIDTH-1:0] data_q;
  logic [AWIDTH-1:0] pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      // Slot is free: either refill it or let it go empty.
      valid_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
        pc_q   <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, addresses a combinational-read
// instruction memory and registers each fetched word into a valid/ready
// stage toward decode. Supports start, redirect with flush, backpressure
// and halt detection.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : leave IDLE and begin fetching from the current PC
//   inc             : PC increment applied after each fetch
//   redirect_valid  : branch/jump request, highest priority
//   redirect_addr   : redirect target
//   mem_addr        : instruction-memory address (always the PC)
//   mem_rdata       : instruction-memory read data
//   instr/instr_pc  : registered word to decode and its fetch address
//   instr_valid     : instr/instr_pc valid
//   instr_ready     : decode accepts this cycle
//   halted          : high in HALT
//   state           : current FSM state (debug)
//
// state | meaning
// IDLE  | waiting for start, PC may be redirected
// RUN   | fetching one word per free output slot
// DRAIN | halt word captured, waiting for it to transfer
// HALT  | stopped, left only by redirect or reset
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                AWIDTH      = 6,
  parameter int                RWIDTH      = 32,
  parameter logic [AWIDTH-1:0] RESET_ADDR  = '0,
  parameter logic [OPC_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] inc,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [RWIDTH-1:0] mem_rdata,
  output logic [RWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic [1:0]        state
);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              load;
  logic              hold;
  logic              xfer;
  logic              is_halt;

  assign hold    = instr_valid & ~instr_ready;
  assign xfer    = instr_valid & instr_ready;
  assign is_halt = (mem_rdata[RWIDTH-1 -: OPC_W] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    if (redirect_valid) begin
      // Redirect beats everything, including a halt word on mem_rdata.
      pc_d = redirect_addr;
      if (state_q != IDLE || start) state_d = RUN;
    end else begin
      case (state_q)
        IDLE:  if (start) state_d = RUN;
        RUN: begin
          if (!hold) begin
            load = 1'b1;
            pc_d = pc_q + inc;
            if (is_halt) state_d = DRAIN;
          end
        end
        DRAIN: if (xfer) state_d = HALT;
        HALT:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flushing in IDLE is harmless: the slot is never valid there.
  fetch_out_stage #(
    .AWIDTH(AWIDTH),
    .RWIDTH(RWIDTH)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .hold_i  (hold),
    .flush_i (redirect_valid),
    .data_i  (mem_rdata),
    .pc_i    (pc_q),
    .valid_o (instr_valid),
    .data_o  (instr),
    .pc_o    (instr_pc)
  );

  assign mem_addr = pc_q;
  assign halted   = (state_q == HALT);
  assign state    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int AW = 6;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst, start, redirect_valid, instr_ready, instr_valid, halted;
  logic [AW-1:0] inc, redirect_addr, mem_addr, instr_pc;
  logic [RW-1:0] mem_rdata, instr;
  logic [1:0]    state;
  logic [RW-1:0] mem [64];

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .inc(inc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .state(state)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int xfer_count [64];

  // Reference model: spec-level view (0 idle, 1 run, 2 drain, 3 halt).
  int          m_pc, m_state, m_ipc;
  bit          m_valid;
  logic [31:0] m_instr;

  typedef struct {
    bit         start;
    bit         ready;
    logic [5:0] exp_pc;
    bit         exp_valid;
    logic [5:0] exp_ipc;
    logic [1:0] exp_state;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_state = 0; m_ipc = 0; m_valid = 0; m_instr = '0;
  endtask

  task automatic model_next();
    bit xfer;
    xfer = m_valid && instr_ready;
    if (!rst) begin
      model_reset();
    end else if (redirect_valid) begin
      m_pc = int'(redirect_addr);
      if (m_state != 0) begin
        m_valid = 0;
        m_state = 1;
      end else if (start) begin
        m_state = 1;
      end
    end else begin
      case (m_state)
        0: if (start) m_state = 1;
        1: if (!m_valid || instr_ready) begin
             m_instr = mem[m_pc];
             m_ipc   = m_pc;
             m_valid = 1;
             if (mem[m_pc][31:26] == 6'h3F) m_state = 2;
             m_pc = (m_pc + int'(inc)) % 64;
           end
        2: if (xfer) begin
             m_valid = 0;
             m_state = 3;
           end
        default: ;
      endcase
    end
  endtask

  task automatic model_check();
    chk("mem_addr", 32'(mem_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    end
    chk("state", 32'(state), 32'(m_state));
    chk("halted", 32'(halted), 32'(m_state == 3));
  endtask

  task automatic step();
    model_next();
    if (instr_valid && instr_ready) xfer_count[instr_pc]++;
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set(input bit st, input bit rdy, input bit rv, input logic [5:0] ra);
    start = st; instr_ready = rdy; redirect_valid = rv; redirect_addr = ra;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'(i);
      xfer_count[i] = 0;
    end
    rst = 1'b0; inc = 6'd1;
    set(0, 1, 0, 0);
    model_reset();
    #1;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_pc", 32'(mem_addr), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", 32'(instr_pc), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // start / streaming / backpressure
    tbl[0]  = '{0, 1, 6'd0, 0, 6'd0, 2'd0};
    tbl[1]  = '{0, 1, 6'd0, 0, 6'd0, 2'd0};
    tbl[2]  = '{1, 1, 6'd0, 0, 6'd0, 2'd1};
    tbl[3]  = '{0, 1, 6'd1, 1, 6'd0, 2'd1};
    tbl[4]  = '{0, 1, 6'd2, 1, 6'd1, 2'd1};
    tbl[5]  = '{0, 1, 6'd3, 1, 6'd2, 2'd1};
    tbl[6]  = '{0, 1, 6'd4, 1, 6'd3, 2'd1};
    tbl[7]  = '{0, 1, 6'd5, 1, 6'd4, 2'd1};
    tbl[8]  = '{0, 1, 6'd6, 1, 6'd5, 2'd1};
    tbl[9]  = '{0, 0, 6'd6, 1, 6'd5, 2'd1};
    tbl[10] = '{0, 0, 6'd6, 1, 6'd5, 2'd1};
    tbl[11] = '{0, 0, 6'd6, 1, 6'd5, 2'd1};
    tbl[12] = '{0, 1, 6'd7, 1, 6'd6, 2'd1};
    tbl[13] = '{0, 1, 6'd8, 1, 6'd7, 2'd1};
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start; instr_ready = tbl[i].ready;
      step();
      chk("tbl_pc", 32'(mem_addr), 32'(tbl[i].exp_pc));
      chk("tbl_valid", 32'(instr_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk("tbl_ipc", 32'(instr_pc), 32'(tbl[i].exp_ipc));
        chk("tbl_instr", instr, 32'(tbl[i].exp_ipc));
      end
      chk("tbl_state", 32'(state), 32'(tbl[i].exp_state));
    end
    chk("bp_no_dup_5", 32'(xfer_count[5]), 1);
    chk("bp_no_loss_6", 32'(xfer_count[6]), 1);

    // redirect discards a stalled word
    set(0, 1, 1, 6'd4); step();
    set(0, 0, 0, 0);    step();
    chk("redir_ipc4", 32'(instr_pc), 4);
    xfer_count[4] = 0;
    set(0, 0, 1, 6'h20); step();
    chk("redir_flush", 32'(instr_valid), 0);
    set(0, 1, 0, 0);    step();
    chk("redir_ipc20", 32'(instr_pc), 32'h20);
    chk("redir_valid", 32'(instr_valid), 1);
    chk("redir_word4_dropped", 32'(xfer_count[4]), 0);

    // halt, drain with a stall, halted, start ignored, redirect out
    mem[7] = 32'hFC00_0000;
    set(0, 1, 1, 6'd5); step();
    set(0, 1, 0, 0);    step(); step(); step();
    chk("halt_drain", 32'(state), 2);
    chk("halt_word", instr, 32'hFC00_0000);
    instr_ready = 0; step();
    chk("halt_drain_hold", 32'(state), 2);
    instr_ready = 1; step();
    chk("halt_state", 32'(state), 3);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_novalid", 32'(instr_valid), 0);
    step(); step();
    set(1, 1, 0, 0); step();
    chk("halt_start_ignored", 32'(state), 3);
    set(0, 1, 1, 6'd0); step();
    chk("halt_exit_run", 32'(state), 1);
    set(0, 1, 0, 0); step();
    chk("halt_exit_fetch0", 32'(instr_pc), 0);

    // redirect beats a halt-word fetch
    set(0, 1, 1, 6'd7);    step();
    set(0, 1, 1, 6'h10);   step();
    chk("redir_vs_halt_state", 32'(state), 1);
    set(0, 1, 0, 0);       step();
    chk("redir_vs_halt_ipc", 32'(instr_pc), 32'h10);

    // PC wrap
    set(0, 1, 1, 6'h3F); step();
    set(0, 1, 0, 0);     step();
    chk("wrap_ipc3f", 32'(instr_pc), 32'h3F);
    chk("wrap_pc0", 32'(mem_addr), 0);
    step();
    chk("wrap_ipc0", 32'(instr_pc), 0);

    // inc = 0 refetches the same word
    inc = 6'd0; step();
    chk("inc0_a", 32'(instr_pc), 1);
    step();
    chk("inc0_b", 32'(instr_pc), 1);
    chk("inc0_pc", 32'(mem_addr), 1);
    inc = 6'd1; step();

    // asynchronous reset between edges
    chk("async_pre_valid", 32'(instr_valid), 1);
    #3 rst = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 0);
    chk("async_pc", 32'(mem_addr), 0);
    chk("async_state", 32'(state), 0);
    chk("async_halted", 32'(halted), 0);
    chk("async_instr", instr, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // randomized run against the model
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[i][31:26] = 6'h3F;
    end
    set(1, 1, 0, 0); step();
    for (int c = 0; c < 600; c++) begin
      start          = ($urandom_range(0, 7) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = 6'($urandom);
      if ($urandom_range(0, 19) == 0) inc = 6'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch path: owns the PC, presents the fetch address to the combinational-read instruction memory, and registers each fetched word into a valid/ready output stage toward decode.
- Provides start, branch/jump redirect with flush, decode backpressure, and halt detection.
- Replaces free-running PC+adder fetch with a sequenced, stallable fetch unit.

Parameters:
- AWIDTH, 6, PC / instruction-memory address width.
- RWIDTH, 32, instruction word width.
- RESET_ADDR, 0, PC value after reset.
- HALT_OPCODE, 6'h3F, value of instruction bits [RWIDTH-1:RWIDTH-6] that marks a halt.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  pulse; begins fetching from the current PC when in IDLE.
- inc  input  AWIDTH  PC increment applied after each fetch.
- redirect_valid  input  1  branch/jump request.
- redirect_addr  input  AWIDTH  redirect target.
- mem_addr  output  AWIDTH  instruction-memory address; always equals the PC.
- mem_rdata  input  RWIDTH  instruction-memory read data, combinational from mem_addr.
- instr  output  RWIDTH  registered instruction to decode.
- instr_pc  output  AWIDTH  address that instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts this cycle.
- halted  output  1  high in HALT state.
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset while rst=0, asynchronous, at any time including mid-fetch:
  - PC = RESET_ADDR; instr = 0; instr_pc = 0; instr_valid = 0; halted = 0; state = IDLE.
- States: IDLE=0, RUN=1, DRAIN=2, HALT=3.
- Handshake:
  - A transfer occurs in any cycle with instr_valid=1 and instr_ready=1.
  - The output slot is free when instr_valid=0 or a transfer occurs this cycle.
  - instr, instr_pc and instr_valid hold stable while instr_valid=1 and instr_ready=0.
- Fetch (RUN, slot free, no redirect):
  - Next edge: instr = mem_rdata, instr_pc = PC, instr_valid = 1, PC = PC + inc.
  - The add is modulo 2^AWIDTH, wrapping with no flag.
  - Latency is one cycle from PC presentation to instr_valid.
  - Sustains one instruction per cycle while instr_ready=1.
- Stall (RUN, slot not free): PC and the output stage hold, and no fetch occurs.
- Redirect (any state except IDLE; highest priority):
  - Next edge: PC = redirect_addr, instr_valid = 0, and the unconsumed output word is discarded.
  - A transfer in the same cycle still counts as delivered.
  - The state becomes RUN, including from DRAIN and from HALT.
  - The first fetch from redirect_addr occurs in the following cycle.
- Redirect in IDLE: PC = redirect_addr; the state remains IDLE.
- IDLE to RUN: on start=1. Redirect and start in the same cycle: PC takes redirect_addr and the state goes to RUN.
- Halt detection, RUN:
  - Applies when a fetch captures a word with mem_rdata[RWIDTH-1:RWIDTH-6] == HALT_OPCODE.
  - The word is delivered normally, PC still advances, and the state goes to DRAIN.
- DRAIN:
  - No fetches.
  - Goes to HALT on the cycle the halt word transfers; the HALT state and halted=1 take effect the next cycle.
- HALT: no fetches, instr_valid=0, halted=1. Exits only by reset or redirect.
- start is ignored outside IDLE.
- Redirect and halt-word fetch in the same cycle: redirect wins and the halt word is not captured.
- inc=0 is legal: the same word is fetched repeatedly.

Decomposition:
- Package fetch_seq_pkg:
  - state_t enum (IDLE, RUN, DRAIN, HALT, 2-bit);
  - HALT_OPCODE default;
  - opcode slice width constant (6).
- One sub-module, fetch_out_stage: single-entry valid/ready output register with load, hold and flush inputs.
- The FSM, PC register and adder stay in the top module.

Test Plan:
- Reset/start, inc=1, memory word[i]=i, no halt opcode, instr_ready=1:
  - Deassert rst, pulse start at cycle 2.
  - instr_valid rises at cycle 3 with instr_pc=0.
  - instr_pc then reads 1, 2, 3 on consecutive cycles.
- Backpressure:
  - Hold instr_ready=0 for 3 cycles while instr_pc=5.
  - instr/instr_pc are held at word5/5, PC stays 6, mem_addr=6.
  - After release, the next word is instr_pc=6 with no loss or duplicate.
- Redirect:
  - Assert redirect_valid with redirect_addr=0x20 while instr_pc=4 is valid and instr_ready=0.
  - Next cycle instr_valid=0; the following cycle instr_pc=0x20; word4 is never transferred.
- Halt: place 0xFC000000 at address 7.
  - word7 is delivered, the state goes to DRAIN, then HALT with halted=1, no further instr_valid.
  - A redirect to 0 returns the state to RUN and fetches address 0.
- Wrap: PC=0x3F, inc=1. Word at 0x3F is delivered, then instr_pc=0x00.
- Async reset mid-run:
  - Drop rst between clock edges while instr_valid=1.
  - Outputs clear immediately, without waiting for a clock edge: instr_valid=0, PC=RESET_ADDR, state=IDLE.
